ad9854_write_sched: RTL and testbench
=====================================

// Module: ad9854_write_sched
// PURPOSE
//  Shares the AD9854 parallel write port between two requesters (e.g. FTW updater, control-reg loader).
//  Sequences the part: power-up MRST pulse, byte-wise register burst writes (WR strobe), then UDCLK update pulse.
//  Round-robin arbitration per burst. Sits between requester logic and the AD9854 pins; write-only (RD held high).
// PARAMETERS
//  MRST_CYC    10  clk cycles MRST held high after reset release
//  WR_LOW_CYC  2   clk cycles WR low per byte (>=1)
//  WR_HIGH_CYC 3   clk cycles WR high after each byte (>=1)
//  UD_CYC      4   clk cycles UDCLK high after last byte (>=1)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  req0_valid  in   1   requester 0 burst request
//  req0_ready  out  1   requester 0 accept strobe (accept = valid & ready)
//  req0_addr   in   6   start register address
//  req0_len    in   3   byte count 0..7 (7 clamped to 6)
//  req0_data   in   48  right-justified data, MS byte sent first
//  req1_valid/req1_ready/req1_addr/req1_len/req1_data: as requester 0
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle pulse when a burst (incl. update pulse) completes
//  MRST        out  1   AD9854 master reset, active high
//  WR          out  1   AD9854 write strobe, active low
//  RD          out  1   AD9854 read strobe, constant 1
//  UDCLK       out  1   AD9854 I/O update, active high
//  A           out  6   register address
//  D           out  8   write data
// BEHAVIOUR
//  - Reset values: MRST=1 WR=1 RD=1 UDCLK=0 A=0 D=0 busy=1 done=0 readyN=0; rr pointer favours req0.
//  - FSM: RESET -> IDLE -> SETUP -> WR_LO -> WR_HI -> (SETUP | UPDATE) -> IDLE.
//  - RESET: MRST=1 for MRST_CYC cycles after rst_n release, then MRST=0, go IDLE.
//  - IDLE: readyN combinational = grant; grant only when validN. Both valid: grant the requester
//    NOT granted last; pointer updates on accept. Latch addr/len/data on accept cycle T.
//  - SETUP (1 cycle): A=addr+k (mod 64), D=data[8*(len-1-k)+:8], WR=1. k=byte index from 0.
//  - WR_LO: WR=0 for WR_LOW_CYC cycles; A/D stable. WR_HI: WR=1 for WR_HIGH_CYC cycles; A/D stable.
//  - After last byte WR_HI: UPDATE, UDCLK=1 for UD_CYC cycles; done=1 on last UPDATE cycle; then IDLE.
//  - Latency: first SETUP at T+1; done at T + len*(1+WR_LOW_CYC+WR_HIGH_CYC) + UD_CYC (defaults: 6*len+4).
//  - A and D hold last driven value in IDLE; WR high and UDCLK low outside WR_LO/UPDATE.
//  - len=0: accepted, no WR/UDCLK activity, done pulses at T+1, back to IDLE. len=7 treated as 6.
//  - Next accept earliest cycle after done; no back-to-back overlap. Inputs ignored while busy.
//  - rst_n low at any time: outputs to reset values immediately (async), in-flight burst discarded,
//    MRST sequence re-runs after release.
//  - All counters sized for max(param)+1; no wrap inside a state; byte counter 3 bits.
// STRUCTURE
//  - ad9854_pkg: state localparams (one-hot), ADDR_FTW1=6'h04, ADDR_CTRL=6'h1D, MAX_LEN=3'd6.
//  - Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], accept, grant[1:0], pointer flop).
//  - Top: FSM, phase counter, byte counter, 48-bit data/addr/len holding registers.
// TESTING
//  1 Release rst_n -> MRST=1 exactly 10 cycles then 0; req0_valid held -> ready only after MRST falls.
//  2 req0 addr=04 len=6 data=48'h0077_33AA_55F5 -> A 04..09, D 00,77,33,AA,55,F5 stable at each WR rise;
//    WR low 2 cycles/byte; UDCLK high 4 cycles; done at T+40.
//  3 req0 and req1 valid together, held -> grant order req0, req1, req0; no byte interleaving.
//  4 req1 addr=3E len=4 data=48'h0000_1122_3344 -> A 3E,3F,00,01; D 11,22,33,44; done at T+28.
//  5 len=0 -> ready pulse, no WR/UDCLK edge, done at T+1; len=7 data=48'hAABB_CCDD_EEFF -> 6 bytes, done T+40.
//  6 rst_n low mid WR_LO of byte 3 -> WR=1, UDCLK=0, MRST=1 same cycle; no done; MRST reruns 10 cycles.

Source files
------------

// File: rtl/ad9854_pkg.sv
// ---------------------------------------------------------------------------
// ad9854_pkg
//   Shared definitions for the AD9854 parallel-port write scheduler.
//   - One-hot FSM state encodings (kept as localparams so older tools that
//     cannot handle enums in ports or casts can still read the design).
//   - Well-known AD9854 register addresses used by the requesters.
//   - Burst descriptor struct and helpers for length clamping, byte
//     selection and parameter maxima.
// ---------------------------------------------------------------------------
package ad9854_pkg;

   localparam int STATE_W = 6;

   localparam logic [STATE_W-1:0] ST_RESET  = 6'b000001;
   localparam logic [STATE_W-1:0] ST_IDLE   = 6'b000010;
   localparam logic [STATE_W-1:0] ST_SETUP  = 6'b000100;
   localparam logic [STATE_W-1:0] ST_WR_LO  = 6'b001000;
   localparam logic [STATE_W-1:0] ST_WR_HI  = 6'b010000;
   localparam logic [STATE_W-1:0] ST_UPDATE = 6'b100000;

   localparam logic [5:0] ADDR_FTW1 = 6'h04;
   localparam logic [5:0] ADDR_CTRL = 6'h1D;
   localparam logic [2:0] MAX_LEN   = 3'd6;

   // One burst as presented by a requester.
   typedef struct packed {
      logic [5:0]  addr;
      logic [2:0]  len;
      logic [47:0] data;
   } burst_t;

   // The AD9854 data is at most 48 bits, so a byte count of 7 cannot be
   // honoured; it is quietly reduced to 6.
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // Data is right-justified and sent MS byte first, so byte k of a burst
   // of length len lives at byte lane (len-1-k).
   function automatic logic [7:0] byte_select(input logic [47:0] data,
                                              input logic [2:0]  len,
                                              input logic [2:0]  k);
      logic [2:0]  idx;
      logic [47:0] shifted;
      idx     = len - k - 3'd1;
      shifted = data >> {idx, 3'b000};
      return shifted[7:0];
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ad9854_write_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. Grant is combinational from the request
//   vector; when both requesters ask, the one that was NOT granted last
//   wins. The priority pointer only moves on an accepted grant, so a
//   requester that is offered the port but never takes it keeps its turn.
//   Ports:
//     clk       in   clock
//     rst_n     in   asynchronous active-low reset (pointer favours req0)
//     i_req     in   [1:0] request vector, already qualified by the caller
//     i_accept  in   the current grant was taken this cycle
//     o_grant   out  [1:0] one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   // 0: requester 0 wins a tie, 1: requester 1 wins a tie
   logic r_prio;

   // Tie goes to the favoured requester, otherwise whoever is asking.
   always_comb begin
      o_grant = 2'b00;
      if (i_req[0] && (!i_req[1] || !r_prio)) begin
         o_grant[0] = 1'b1;
      end else if (i_req[1]) begin
         o_grant[1] = 1'b1;
      end
   end

   // After an accepted grant the other requester becomes favoured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (i_accept) begin
         r_prio <= o_grant[0];
      end
   end

endmodule

// File: rtl/ad9854_write_sched.sv
// ---------------------------------------------------------------------------
// ad9854_write_sched
//   Shares the AD9854 parallel write port between two requesters. After
//   reset the part is held in master reset for MRST_CYC cycles. Each
//   accepted burst is written byte by byte (SETUP, WR low, WR high per
//   byte, address incrementing mod 64, MS data byte first) and finished
//   with a UDCLK pulse that transfers the new values into the DDS core.
//   Bursts are arbitrated round-robin and never interleave.
//   Ports:
//     clk, rst_n                clock, asynchronous active-low reset
//     reqN_valid/reqN_ready     burst handshake, accept = valid & ready
//     reqN_addr [5:0]           start register address
//     reqN_len  [2:0]           byte count 0..7 (7 treated as 6)
//     reqN_data [47:0]          right-justified burst data
//     busy                      high whenever the FSM is not in IDLE
//     done                      one-cycle pulse at the end of a burst
//     MRST, WR, RD, UDCLK       AD9854 control pins (WR active low, RD = 1)
//     A [5:0], D [7:0]          AD9854 address and data buses
// ---------------------------------------------------------------------------
module ad9854_write_sched
   import ad9854_pkg::*;
#(
   parameter int MRST_CYC    = 10,
   parameter int WR_LOW_CYC  = 2,
   parameter int WR_HIGH_CYC = 3,
   parameter int UD_CYC      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [5:0]  req0_addr,
   input  logic [2:0]  req0_len,
   input  logic [47:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [5:0]  req1_addr,
   input  logic [2:0]  req1_len,
   input  logic [47:0] req1_data,
   output logic        busy,
   output logic        done,
   output logic        MRST,
   output logic        WR,
   output logic        RD,
   output logic        UDCLK,
   output logic [5:0]  A,
   output logic [7:0]  D
);

   localparam int MAX_CYC = max4(MRST_CYC, WR_LOW_CYC, WR_HIGH_CYC, UD_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   logic [STATE_W-1:0] r_state;
   logic [CNT_W-1:0]   r_phase;
   logic [2:0]         r_byte;
   logic [2:0]         r_len;
   logic [47:0]        r_data;
   logic [5:0]         r_a;
   logic [7:0]         r_d;
   logic               r_zero_done;

   logic [1:0]         w_req;
   logic [1:0]         w_grant;
   logic               w_accept;
   logic               w_can_grant;
   burst_t             w_in;
   logic [2:0]         w_clen;
   logic               w_mrst_last;
   logic               w_wrlo_last;
   logic               w_wrhi_last;
   logic               w_ud_last;

   // A zero-length burst produces its done pulse while the FSM already sits
   // in IDLE; holding off grants during that cycle keeps "next accept only
   // after done" true for every burst length.
   assign w_can_grant = (r_state == ST_IDLE) && !r_zero_done;
   assign w_req       = {req1_valid, req0_valid} & {2{w_can_grant}};
   assign w_accept    = |w_grant;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_req),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // Burst of the requester currently being granted.
   always_comb begin
      if (w_grant[1]) begin
         w_in = '{addr: req1_addr, len: req1_len, data: req1_data};
      end else begin
         w_in = '{addr: req0_addr, len: req0_len, data: req0_data};
      end
   end

   assign w_clen      = clamp_len(w_in.len);
   assign w_mrst_last = (r_phase == CNT_W'(MRST_CYC - 1));
   assign w_wrlo_last = (r_phase == CNT_W'(WR_LOW_CYC - 1));
   assign w_wrhi_last = (r_phase == CNT_W'(WR_HIGH_CYC - 1));
   assign w_ud_last   = (r_phase == CNT_W'(UD_CYC - 1));

   // Main sequencer. The phase counter restarts from zero on entry to every
   // timed state, so each state's length is independent of the others.
   // A/D are registered and loaded on the edge that enters SETUP, which
   // gives a full SETUP cycle before WR falls and keeps them stable until
   // the next byte (or indefinitely in IDLE).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RESET;
         r_phase     <= '0;
         r_byte      <= 3'd0;
         r_len       <= 3'd0;
         r_data      <= 48'd0;
         r_a         <= 6'd0;
         r_d         <= 8'd0;
         r_zero_done <= 1'b0;
      end else begin
         r_zero_done <= 1'b0;
         case (r_state)
            ST_RESET: begin
               if (w_mrst_last) begin
                  r_state <= ST_IDLE;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  r_len  <= w_clen;
                  r_data <= w_in.data;
                  r_byte <= 3'd0;
                  if (w_clen == 3'd0) begin
                     r_zero_done <= 1'b1;
                  end else begin
                     r_state <= ST_SETUP;
                     r_a     <= w_in.addr;
                     r_d     <= byte_select(w_in.data, w_clen, 3'd0);
                  end
               end
            end
            ST_SETUP: begin
               r_state <= ST_WR_LO;
               r_phase <= '0;
            end
            ST_WR_LO: begin
               if (w_wrlo_last) begin
                  r_state <= ST_WR_HI;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            ST_WR_HI: begin
               if (w_wrhi_last) begin
                  r_phase <= '0;
                  if (r_byte == r_len - 3'd1) begin
                     r_state <= ST_UPDATE;
                  end else begin
                     r_state <= ST_SETUP;
                     r_byte  <= r_byte + 3'd1;
                     r_a     <= r_a + 6'd1;
                     r_d     <= byte_select(r_data, r_len, r_byte + 3'd1);
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            ST_UPDATE: begin
               if (w_ud_last) begin
                  r_state <= ST_IDLE;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            default: begin
               r_state <= ST_RESET;
               r_phase <= '0;
            end
         endcase
      end
   end

   // Pin and status outputs decode straight from registered state, so an
   // asynchronous reset reaches the part in the same cycle.
   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];
   assign busy       = (r_state != ST_IDLE);
   assign done       = ((r_state == ST_UPDATE) && w_ud_last) || r_zero_done;
   assign MRST       = (r_state == ST_RESET);
   assign WR         = (r_state != ST_WR_LO);
   assign RD         = 1'b1;
   assign UDCLK      = (r_state == ST_UPDATE);
   assign A          = r_a;
   assign D          = r_d;

endmodule

// File: tb/tb_ad9854_write_sched.sv
// ---------------------------------------------------------------------------
// tb_ad9854_write_sched
//   Directed bench for the AD9854 write scheduler. Drivers push expected
//   grants, byte writes and done cycles into queues; an independent
//   monitor pops and compares them whenever the DUT shows an accept, a WR
//   rising edge or a done pulse.
// ---------------------------------------------------------------------------
module tb_ad9854_write_sched;
   import ad9854_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req0_valid;
   logic        req0_ready;
   logic [5:0]  req0_addr;
   logic [2:0]  req0_len;
   logic [47:0] req0_data;
   logic        req1_valid;
   logic        req1_ready;
   logic [5:0]  req1_addr;
   logic [2:0]  req1_len;
   logic [47:0] req1_data;
   logic        busy;
   logic        done;
   logic        MRST;
   logic        WR;
   logic        RD;
   logic        UDCLK;
   logic [5:0]  A;
   logic [7:0]  D;

   int          nChecks = 0;
   int          nFail   = 0;
   int          cyc     = 0;
   int          lastAcceptCyc = 0;

   int          expGrantQ[$];
   logic [13:0] expByteQ[$];
   int          expDoneQ[$];

   int          wrFallCnt = 0;
   int          udRiseCnt = 0;

   ad9854_write_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_len   (req0_len),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_len   (req1_len),
      .req1_data  (req1_data),
      .busy       (busy),
      .done       (done),
      .MRST       (MRST),
      .WR         (WR),
      .RD         (RD),
      .UDCLK      (UDCLK),
      .A          (A),
      .D          (D)
   );

   // 10-unit clock and a cycle index that the checks use as a time base.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point shared by driver and monitor.
   task automatic checkOutput(input string name, input logic [47:0] actual,
                              input logic [47:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   // Record expected bytes (MS-first packed tables) and done cycle for a
   // burst accepted in the current cycle.
   task automatic pushBurst(input logic [47:0] expA, input logic [47:0] expD,
                            input int nBytes, input int lat);
      logic [7:0] a8;
      logic [7:0] d8;
      lastAcceptCyc = cyc;
      for (int k = 0; k < nBytes; k++) begin
         a8 = expA[47-8*k -: 8];
         d8 = expD[47-8*k -: 8];
         expByteQ.push_back({a8[5:0], d8});
      end
      expDoneQ.push_back(cyc + lat);
   endtask

   // Present one burst on one requester and hold it until accepted.
   task automatic applyStimulus(input int id, input logic [5:0] addr,
                                input logic [2:0] len, input logic [47:0] data,
                                input logic [47:0] expA, input logic [47:0] expD,
                                input int nBytes, input int lat);
      bit got;
      got = 0;
      expGrantQ.push_back(id);
      @(posedge clk);
      #1;
      if (id == 0) begin
         req0_valid = 1'b1; req0_addr = addr; req0_len = len; req0_data = data;
      end else begin
         req1_valid = 1'b1; req1_addr = addr; req1_len = len; req1_data = data;
      end
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
            pushBurst(expA, expD, nBytes, lat);
            got = 1;
         end
      end
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         checkOutput("acceptTimeout", 48'd0, 48'd1);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Wait for the scoreboard's done queue to drain and the DUT to idle.
   task automatic waitIdle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (expDoneQ.size() == 0 && !busy) ok = 1;
      end
      checkOutput("idleReached", 48'(ok), 48'd1);
      checkOutput("byteQueueDrained", 48'(expByteQ.size()), 48'd0);
   endtask

   // Release reset at a negedge and measure how long MRST stays high.
   task automatic measureMrst(output int count, output bit early);
      count = 0;
      early = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         count++;
         if (!MRST) break;
         if (req0_ready || req1_ready) early = 1;
      end
   endtask

   // Monitor: compares DUT activity against the expectation queues.
   initial begin
      bit prevWr;
      bit prevUd;
      int wrLowRun;
      int udRun;
      int e;
      logic [13:0] eb;
      prevWr = 1; prevUd = 0; wrLowRun = 0; udRun = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevWr = 1; prevUd = 0; wrLowRun = 0; udRun = 0;
         end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
               if (expGrantQ.size() == 0) begin
                  checkOutput("grantUnexpected", 48'd1, 48'd0);
               end else begin
                  e = expGrantQ.pop_front();
                  checkOutput("grantId", 48'(req1_ready), 48'(e));
               end
            end
            if (!WR) wrLowRun++;
            if (!WR && prevWr) wrFallCnt++;
            if (WR && !prevWr) begin
               checkOutput("wrLowCycles", 48'(wrLowRun), 48'd2);
               wrLowRun = 0;
               if (expByteQ.size() == 0) begin
                  checkOutput("byteUnexpected", {36'd0, A, D}, 48'd0);
               end else begin
                  eb = expByteQ.pop_front();
                  checkOutput("byteAddrData", {34'd0, A, D}, {34'd0, eb});
               end
            end
            if (UDCLK) udRun++;
            if (UDCLK && !prevUd) udRiseCnt++;
            if (!UDCLK && prevUd) begin
               checkOutput("udclkHighCycles", 48'(udRun), 48'd4);
               udRun = 0;
            end
            if (done) begin
               if (expDoneQ.size() == 0) begin
                  checkOutput("doneUnexpected", 48'(cyc), 48'd0);
               end else begin
                  e = expDoneQ.pop_front();
                  checkOutput("doneCycle", 48'(cyc), 48'(e));
               end
            end
            prevWr = WR;
            prevUd = UDCLK;
         end
      end
   end

   // Directed sequence.
   initial begin
      int  mrstCnt;
      bit  early;
      int  n;
      int  wrBefore;
      int  udBefore;

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_addr = 6'd0; req0_len = 3'd0; req0_data = 48'd0;
      req1_valid = 1'b0; req1_addr = 6'd0; req1_len = 3'd0; req1_data = 48'd0;

      // Reset values while rst_n is low.
      repeat (3) @(negedge clk);
      checkOutput("rstMRST",  48'(MRST),  48'd1);
      checkOutput("rstWR",    48'(WR),    48'd1);
      checkOutput("rstRD",    48'(RD),    48'd1);
      checkOutput("rstUDCLK", 48'(UDCLK), 48'd0);
      checkOutput("rstA",     48'(A),     48'd0);
      checkOutput("rstD",     48'(D),     48'd0);
      checkOutput("rstBusy",  48'(busy),  48'd1);
      checkOutput("rstDone",  48'(done),  48'd0);
      checkOutput("rstReady", {46'd0, req1_ready, req0_ready}, 48'd0);

      // Test 1: MRST width; req0 (zero-length) held through reset release.
      $display("[TB] test 1: MRST sequence");
      expGrantQ.push_back(0);
      req0_valid = 1'b1; req0_addr = ADDR_FTW1; req0_len = 3'd0;
      measureMrst(mrstCnt, early);
      checkOutput("mrstHighCycles", 48'(mrstCnt), 48'd10);
      checkOutput("readyBeforeMrstLow", 48'(early), 48'd0);
      checkOutput("readyAfterMrstLow", 48'(req0_ready), 48'd1);
      if (req0_ready) pushBurst(48'd0, 48'd0, 0, 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      waitIdle();

      // Test 2: full six-byte FTW-style burst.
      $display("[TB] test 2: six-byte burst from req0");
      applyStimulus(0, ADDR_FTW1, 3'd6, 48'h0077_33AA_55F5,
                    48'h0405_0607_0809, 48'h0077_33AA_55F5, 6, 40);
      waitIdle();
      checkOutput("aHoldIdle", 48'(A), 48'h09);
      checkOutput("dHoldIdle", 48'(D), 48'hF5);
      checkOutput("wrHighIdle", 48'(WR), 48'd1);

      // Test 4 (run before 3 so the pointer favours req0): address wrap.
      $display("[TB] test 4: req1 burst with address wrap");
      applyStimulus(1, 6'h3E, 3'd4, 48'h0000_1122_3344,
                    48'h3E3F_0001_0000, 48'h1122_3344_0000, 4, 28);
      waitIdle();

      // Test 3: both requesters held -> req0, req1, req0.
      $display("[TB] test 3: round-robin with both requesters held");
      expGrantQ.push_back(0);
      expGrantQ.push_back(1);
      expGrantQ.push_back(0);
      @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_addr = ADDR_CTRL; req0_len = 3'd2; req0_data = 48'h0000_0000_BEEF;
      req1_valid = 1'b1; req1_addr = 6'h3F;     req1_len = 3'd1; req1_data = 48'h0000_0000_005A;
      n = 0;
      for (int i = 0; i < 300 && n < 3; i++) begin
         @(negedge clk);
         if (req0_ready) begin
            pushBurst(48'h1D1E_0000_0000, 48'hBEEF_0000_0000, 2, 16);
            n++;
         end else if (req1_ready) begin
            pushBurst(48'h3F00_0000_0000, 48'h5A00_0000_0000, 1, 10);
            n++;
         end
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("rrGrantCount", 48'(n), 48'd3);
      waitIdle();

      // Test 5: zero-length burst, then length 7 clamped to 6.
      $display("[TB] test 5: len=0 and len=7");
      wrBefore = wrFallCnt;
      udBefore = udRiseCnt;
      applyStimulus(0, ADDR_CTRL, 3'd0, 48'h1234_5678_9ABC, 48'd0, 48'd0, 0, 1);
      waitIdle();
      checkOutput("len0NoWr",    48'(wrFallCnt), 48'(wrBefore));
      checkOutput("len0NoUdclk", 48'(udRiseCnt), 48'(udBefore));
      applyStimulus(0, ADDR_CTRL, 3'd7, 48'hAABB_CCDD_EEFF,
                    48'h1D1E_1F20_2122, 48'hAABB_CCDD_EEFF, 6, 40);
      waitIdle();

      // Test 6: async reset in WR_LO of byte index 3.
      $display("[TB] test 6: reset mid-burst");
      applyStimulus(0, ADDR_FTW1, 3'd6, 48'h0102_0304_0506,
                    48'h0405_0607_0809, 48'h0102_0304_0506, 6, 40);
      while (cyc < lastAcceptCyc + 20) @(negedge clk);
      checkOutput("wrLowBeforeReset", 48'(WR), 48'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncWR",    48'(WR),    48'd1);
      checkOutput("asyncUDCLK", 48'(UDCLK), 48'd0);
      checkOutput("asyncMRST",  48'(MRST),  48'd1);
      checkOutput("asyncA",     48'(A),     48'd0);
      expByteQ.delete();
      expDoneQ.delete();
      repeat (3) @(negedge clk);
      measureMrst(mrstCnt, early);
      checkOutput("mrstRerunCycles", 48'(mrstCnt), 48'd10);
      repeat (5) @(negedge clk);
      checkOutput("idleAfterRerun", 48'(busy), 48'd0);
      checkOutput("grantQueueDrained", 48'(expGrantQ.size()), 48'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
